// File: rtl/sub64_serial_if.sv
// sub64_serial_if: operand/result handshake bundle for the serial subtractor
// Ports (signals):
//    in_valid/in_ready  operand handshake, a = minuend, b = subtrahend, bin = borrow-in
//    out_valid/out_ready result handshake, d = difference, bout = borrow-out,
//    v = signed overflow, z = zero flag
// Modports: master drives operands and consumes results, slave is the subtractor.
interface sub64_serial_if #(parameter int WIDTH = 64);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             v;
   logic             z;
   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, d, bout, v, z
   );
   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, d, bout, v, z
   );
endinterface

// File: rtl/sub64_serial.sv
// sub64_serial: multi-cycle a - b - bin, one SLICE_W-bit slice per clock, lsb slice first
// Ports:
//    clk  rising-edge clock
//    rst  asynchronous active-high reset, aborts any operation in flight
//    bus  sub64_serial_if.slave: operands in, d/bout/v/z out, valid/ready both sides
module sub64_serial #(
   parameter int WIDTH   = 64,
   parameter int SLICE_W = 16
) (
   input logic            clk,
   input logic            rst,
   sub64_serial_if.slave  bus
);
   localparam int N  = WIDTH / SLICE_W;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   if (WIDTH % SLICE_W != 0) begin : g_bad_slice
      $error("SLICE_W must divide WIDTH");
   end
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] a_r, b_r, d_r, d_nx;
   logic [KW-1:0]    k;
   logic             carry, last, bout_r, v_r, z_r;
   logic [SLICE_W:0] sum;
   int               base;
   assign last = k == KW'(N - 1);
   // Subtraction as a + ~b + carry; carry is preloaded with ~bin, so borrow = ~carry.
   always_comb begin
      base = int'(k) * SLICE_W;
      sum  = {1'b0, a_r[base +: SLICE_W]} + {1'b0, ~b_r[base +: SLICE_W]} + {{SLICE_W{1'b0}}, carry};
      d_nx = d_r;
      d_nx[base +: SLICE_W] = sum[SLICE_W-1:0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = bus.in_valid ? RUN : IDLE;
         RUN:     state_nx = last ? DONE : RUN;
         DONE:    state_nx = bus.out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         d_r    <= '0;
         k      <= '0;
         carry  <= 1'b0;
         bout_r <= 1'b0;
         v_r    <= 1'b0;
         z_r    <= 1'b0;
      end else begin
         if (state == IDLE && bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            carry <= ~bus.bin;
            k     <= '0;
         end
         if (state == RUN) begin
            d_r   <= d_nx;
            carry <= sum[SLICE_W];
            k     <= last ? '0 : k + 1'b1;
            // Flags come from the fully assembled difference, which only exists on the last slice.
            if (last) begin
               bout_r <= ~sum[SLICE_W];
               v_r    <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d_nx[WIDTH-1] != a_r[WIDTH-1]);
               z_r    <= d_nx == '0;
            end
         end
      end
   end
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.d         = d_r;
   assign bus.bout      = bout_r;
   assign bus.v         = v_r;
   assign bus.z         = z_r;
endmodule

// File: tb/tb_sub64_serial.sv
// tb_sub64_serial: directed self-checking bench for sub64_serial
module tb_sub64_serial;
   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   logic [63:0] rd;
   logic        rb, rv, rz, to;
   int          lat;
   always #5 clk = ~clk;
   sub64_serial_if #(.WIDTH(64)) bus();
   sub64_serial #(.WIDTH(64), .SLICE_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   // Presents operands once in_ready is seen, returns at the negedge after the accept edge.
   task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic bin, output logic tmo);
      int c = 0;
      @(negedge clk);
      while (!bus.in_ready && c < 20) begin
         @(negedge clk);
         c++;
      end
      tmo = !bus.in_ready;
      bus.a = a;
      bus.b = b;
      bus.bin = bin;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   task automatic wait_done(output int cyc, output logic tmo);
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      tmo = !bus.out_valid;
   endtask
   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bin,
                         output logic [63:0] d, output logic bo, output logic vo, output logic zo,
                         output int cyc, output logic tmo);
      logic t1, t2;
      bus.out_ready = 1'b1;
      start_op(a, b, bin, t1);
      wait_done(cyc, t2);
      tmo = t1 | t2;
      d = bus.d;
      bo = bus.bout;
      vo = bus.v;
      zo = bus.z;
      @(negedge clk);
   endtask
   task automatic test_reset;
      rst = 1'b1;
      #12;
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      tests++; if (bus.d !== 64'd0) begin fails++; $display("FAIL reset_d: got %h expected 0", bus.d); end
      tests++; if ({bus.bout, bus.v, bus.z} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {bus.bout, bus.v, bus.z}); end
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic test_basic;
      run_op(64'd5, 64'd3, 1'b0, rd, rb, rv, rz, lat, to);
      tests++; if (to !== 1'b0) begin fails++; $display("FAIL basic_timeout: got %b expected 0", to); end
      tests++; if (lat != 4) begin fails++; $display("FAIL basic_latency: got %0d expected 4", lat); end
      tests++; if (rd !== 64'd2) begin fails++; $display("FAIL basic_d: got %h expected %h", rd, 64'd2); end
      tests++; if ({rb, rv, rz} !== 3'b000) begin fails++; $display("FAIL basic_flags: got %b expected 000", {rb, rv, rz}); end
   endtask
   task automatic test_underflow;
      run_op(64'd0, 64'd1, 1'b0, rd, rb, rv, rz, lat, to);
      tests++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL under_d: got %h expected ffffffffffffffff", rd); end
      tests++; if ({rb, rv, rz} !== 3'b100) begin fails++; $display("FAIL under_flags: got %b expected 100", {rb, rv, rz}); end
      run_op(64'd7, 64'd7, 1'b1, rd, rb, rv, rz, lat, to);
      tests++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL binq_d: got %h expected ffffffffffffffff", rd); end
      tests++; if ({rb, rz} !== 2'b10) begin fails++; $display("FAIL binq_flags: got %b expected 10", {rb, rz}); end
   endtask
   task automatic test_cross_slice;
      run_op(64'h0000_0001_0000_0000, 64'd1, 1'b0, rd, rb, rv, rz, lat, to);
      tests++; if (rd !== 64'h0000_0000_FFFF_FFFF) begin fails++; $display("FAIL cross_d: got %h expected 00000000ffffffff", rd); end
      tests++; if ({rb, rv, rz} !== 3'b000) begin fails++; $display("FAIL cross_flags: got %b expected 000", {rb, rv, rz}); end
      run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, rd, rb, rv, rz, lat, to);
      tests++; if (rd !== 64'd0) begin fails++; $display("FAIL equal_d: got %h expected 0", rd); end
      tests++; if ({rb, rv, rz} !== 3'b001) begin fails++; $display("FAIL equal_flags: got %b expected 001", {rb, rv, rz}); end
   endtask
   task automatic test_overflow;
      run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, rd, rb, rv, rz, lat, to);
      tests++; if (rd !== 64'h7FFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL ovf_d: got %h expected 7fffffffffffffff", rd); end
      tests++; if ({rb, rv, rz} !== 3'b010) begin fails++; $display("FAIL ovf_flags: got %b expected 010", {rb, rv, rz}); end
   endtask
   task automatic test_back_to_back;
      bus.out_ready = 1'b0;
      start_op(64'd100, 64'd58, 1'b0, to);
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_run_in_ready: got %b expected 0", bus.in_ready); end
      bus.a = 64'd1000;
      bus.b = 64'd1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_done(lat, to);
      tests++; if (to !== 1'b0) begin fails++; $display("FAIL bp_timeout: got %b expected 0", to); end
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, bus.out_valid); end
         tests++; if (bus.d !== 64'd42) begin fails++; $display("FAIL bp_hold_d%0d: got %h expected %h", i, bus.d, 64'd42); end
         tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_in_ready%0d: got %b expected 0", i, bus.in_ready); end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      tests++; if (bus.d !== 64'd42) begin fails++; $display("FAIL bp_final_d: got %h expected %h", bus.d, 64'd42); end
      bus.out_ready = 1'b1;
      @(negedge clk);
      tests++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin fails++; $display("FAIL bp_release: got %b expected 01", {bus.out_valid, bus.in_ready}); end
      bus.a = 64'd9;
      bus.b = 64'd2;
      bus.bin = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_next_accept: got %b expected 0", bus.in_ready); end
      wait_done(lat, to);
      tests++; if (lat != 4) begin fails++; $display("FAIL bp_next_latency: got %0d expected 4", lat); end
      tests++; if (bus.d !== 64'd7) begin fails++; $display("FAIL bp_next_d: got %h expected %h", bus.d, 64'd7); end
      @(negedge clk);
   endtask
   task automatic test_reset_mid_run;
      bus.out_ready = 1'b1;
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, to);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin fails++; $display("FAIL midrst_state: got %b expected 01", {bus.out_valid, bus.in_ready}); end
      tests++; if (bus.d !== 64'd0) begin fails++; $display("FAIL midrst_d: got %h expected 0", bus.d); end
      @(negedge clk);
      rst = 1'b0;
      run_op(64'd10, 64'd4, 1'b0, rd, rb, rv, rz, lat, to);
      tests++; if (to !== 1'b0) begin fails++; $display("FAIL midrst_timeout: got %b expected 0", to); end
      tests++; if (lat != 4) begin fails++; $display("FAIL midrst_latency: got %0d expected 4", lat); end
      tests++; if (rd !== 64'd6) begin fails++; $display("FAIL midrst_d_after: got %h expected %h", rd, 64'd6); end
      tests++; if ({rb, rv, rz} !== 3'b000) begin fails++; $display("FAIL midrst_flags: got %b expected 000", {rb, rv, rz}); end
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.bin = 1'b0;
      bus.out_ready = 1'b0;
      test_reset;
      test_basic;
      test_underflow;
      test_cross_slice;
      test_overflow;
      test_back_to_back;
      test_reset_mid_run;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
